equiv_sweep_checker: RTL and testbench

- Sequential exhaustive-equivalence stage that wraps a pair of combinational circuits under comparison: a reference form and a simplified form.
- Upstream role: drives their shared input vector through every combination 0..2^N_INPUTS-1.
- Downstream role: samples both outputs per vector, counts mismatches, captures the first failing vector and reports pass/fail.
- Replaces hand-written per-vector test blocks with one reusable checker in the top-level design.

---
 rtl/equiv_sweep_checker_pkg.sv | 12 +
 rtl/equiv_sweep_checker_if.sv | 25 ++
 rtl/equiv_sweep_checker_sweep_counter.sv | 24 ++
 rtl/equiv_sweep_checker.sv | 93 +++++++++
 tb/tb_equiv_sweep_checker.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/equiv_sweep_checker_pkg.sv
// Shared types and constants for the exhaustive-equivalence sweep checker.
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/equiv_sweep_checker_if.sv
// Bundle between the checker and the two circuits under comparison plus its control/status.
interface equiv_sweep_checker_if #(
    parameter int N_INPUTS = 3
);
    logic                start;
    logic [N_INPUTS-1:0] vec;
    logic                q_ref;
    logic                q_dut;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   mismatch_count;
    logic                first_fail_valid;
    logic [N_INPUTS-1:0] first_fail_vec;

    modport master (
        input  start, q_ref, q_dut,
        output vec, busy, done, pass, mismatch_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, q_ref, q_dut,
        input  vec, busy, done, pass, mismatch_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/equiv_sweep_checker_sweep_counter.sv
// Input-vector register: clear to zero, step by one, flag the all-ones terminal vector.
module sweep_counter #(
    parameter int N_INPUTS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [N_INPUTS-1:0] vec,
    output logic                last
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            vec <= '0;
        end else if (inc) begin
            vec <= vec + N_INPUTS'(1);
        end
    end

    assign last = &vec;

endmodule

// File: rtl/equiv_sweep_checker.sv
// Sweeps a shared input vector over all 2^N_INPUTS values, comparing two circuit outputs per vector.
module equiv_sweep_checker
    import checker_pkg::*;
#(
    parameter int N_INPUTS = 3,
    parameter int SETTLE   = 0
) (
    input logic                   clk,
    input logic                   reset,
    equiv_sweep_checker_if.master bus
);

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [N_INPUTS-1:0]   vec_q;
    logic                  last;
    logic                  clr;
    logic                  inc;
    logic                  sample;
    logic [N_INPUTS:0]     mismatch_count_q;
    logic                  first_fail_valid_q;
    logic [N_INPUTS-1:0]   first_fail_vec_q;

    assign sample = (state_q == RUN) && (settle_cnt == SETTLE_W'(SETTLE));

    sweep_counter #(.N_INPUTS(N_INPUTS)) u_sweep_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .vec   (vec_q),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (sample) begin
                    if (last) state_d = DONE;
                    else      inc     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Settle timing and result capture; start while in RUN never reaches clr.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            settle_cnt         <= '0;
            mismatch_count_q   <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_vec_q   <= '0;
        end else if (state_q == RUN) begin
            if (sample) begin
                settle_cnt <= '0;
                if (bus.q_ref != bus.q_dut) begin
                    mismatch_count_q <= mismatch_count_q + (N_INPUTS+1)'(1);
                    if (!first_fail_valid_q) begin
                        first_fail_valid_q <= 1'b1;
                        first_fail_vec_q   <= vec_q;
                    end
                end
            end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
        end
    end

    assign bus.vec              = vec_q;
    assign bus.busy             = (state_q == RUN);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = (state_q == DONE) && (mismatch_count_q == '0);
    assign bus.mismatch_count   = mismatch_count_q;
    assign bus.first_fail_valid = first_fail_valid_q;
    assign bus.first_fail_vec   = first_fail_vec_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Directed, table-driven bench for equiv_sweep_checker (N=3 with SETTLE=0 and SETTLE=2).
module tb_equiv_sweep_checker;

    typedef struct {
        logic [1:0] mode;       // 0 identical, 1 fault at vec 5, 2 inverted
        logic [3:0] exp_count;
        logic       exp_ffv;
        logic [2:0] exp_ffvec;
        logic       exp_pass;
    } sweep_vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] mode0;
    int         n_cmp;
    int         n_fail;
    sweep_vec_t tbl [4];

    equiv_sweep_checker_if #(.N_INPUTS(3)) bus0 ();
    equiv_sweep_checker_if #(.N_INPUTS(3)) bus1 ();

    equiv_sweep_checker #(.N_INPUTS(3), .SETTLE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    equiv_sweep_checker #(.N_INPUTS(3), .SETTLE(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Reference circuit b&(a|c), a = vec MSB.
    assign bus0.q_ref = bus0.vec[1] & (bus0.vec[2] | bus0.vec[0]);
    assign bus0.q_dut = (mode0 == 2'd0) ? bus0.q_ref :
                        (mode0 == 2'd1) ? (bus0.q_ref ^ (bus0.vec == 3'd5)) : ~bus0.q_ref;
    assign bus1.q_ref = bus1.vec[1] & (bus1.vec[2] | bus1.vec[0]);
    assign bus1.q_dut = bus1.vec[1] & (bus1.vec[2] | bus1.vec[0]);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " vec"},   32'(bus0.vec), 32'd0);
        check({tag, " busy"},  32'(bus0.busy), 32'd0);
        check({tag, " done"},  32'(bus0.done), 32'd0);
        check({tag, " pass"},  32'(bus0.pass), 32'd0);
        check({tag, " count"}, 32'(bus0.mismatch_count), 32'd0);
        check({tag, " ffv"},   32'(bus0.first_fail_valid), 32'd0);
        check({tag, " ffvec"}, 32'(bus0.first_fail_vec), 32'd0);
    endtask

    // Start pulse at cycle T, vec 0..7 on T+1..T+8, results at T+9.
    task automatic run_sweep(input sweep_vec_t t, input string tag);
        @(negedge clk);
        mode0      = t.mode;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check({tag, " cleared count"}, 32'(bus0.mismatch_count), 32'd0);
        check({tag, " cleared ffv"},   32'(bus0.first_fail_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check({tag, " vec step"}, 32'(bus0.vec), 32'(i));
            check({tag, " busy"},     32'(bus0.busy), 32'd1);
            check({tag, " not done"}, 32'(bus0.done), 32'd0);
            @(negedge clk);
        end
        check({tag, " done"},  32'(bus0.done), 32'd1);
        check({tag, " idle"},  32'(bus0.busy), 32'd0);
        check({tag, " vec"},   32'(bus0.vec), 32'd7);
        check({tag, " pass"},  32'(bus0.pass), 32'(t.exp_pass));
        check({tag, " count"}, 32'(bus0.mismatch_count), 32'(t.exp_count));
        check({tag, " ffv"},   32'(bus0.first_fail_valid), 32'(t.exp_ffv));
        check({tag, " ffvec"}, 32'(bus0.first_fail_vec), 32'(t.exp_ffvec));
        @(negedge clk);
        check({tag, " done held"}, 32'(bus0.done), 32'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        mode0      = 2'd0;
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        // Last entry restarts from the failing DONE with identical circuits.
        tbl[0] = '{mode: 2'd0, exp_count: 4'd0, exp_ffv: 1'b0, exp_ffvec: 3'd0, exp_pass: 1'b1};
        tbl[1] = '{mode: 2'd1, exp_count: 4'd1, exp_ffv: 1'b1, exp_ffvec: 3'd5, exp_pass: 1'b0};
        tbl[2] = '{mode: 2'd2, exp_count: 4'd8, exp_ffv: 1'b1, exp_ffvec: 3'd0, exp_pass: 1'b0};
        tbl[3] = '{mode: 2'd0, exp_count: 4'd0, exp_ffv: 1'b0, exp_ffvec: 3'd0, exp_pass: 1'b1};

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        foreach (tbl[k]) run_sweep(tbl[k], $sformatf("sweep%0d", k));

        // Abort with reset while vec=3; inverted circuits so partial results are nonzero.
        @(negedge clk);
        mode0      = 2'd2;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort vec before reset",   32'(bus0.vec), 32'd3);
        check("abort count before reset", 32'(bus0.mismatch_count), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("abort");
        run_sweep(tbl[1], "after_abort");

        // SETTLE=2: each vec held 3 cycles, done at T+25, starts at T+5 and T+12 ignored.
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 24; c++) begin
            bus1.start = (c == 5) || (c == 12);
            check("settle vec",  32'(bus1.vec), 32'((c - 1) / 3));
            check("settle busy", 32'(bus1.busy), 32'd1);
            @(negedge clk);
        end
        bus1.start = 1'b0;
        check("settle done",  32'(bus1.done), 32'd1);
        check("settle pass",  32'(bus1.pass), 32'd1);
        check("settle count", 32'(bus1.mismatch_count), 32'd0);
        check("settle ffv",   32'(bus1.first_fail_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
